// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. It drives the shared ALU in subtract mode
// through a 32-step restoring division, then applies the sign fix-up on the selected result.
module alu_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_fn,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf
);

  typedef enum logic [2:0] {
    S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_SIGN, S_DONE
  } state_t;

  localparam logic [3:0] FN_SUB = 4'b0001;

  state_t state, state_d;

  logic [XLEN-1:0] a_abs, b_abs, r_q, q_q;
  logic            r_msb;
  logic [4:0]      cnt;
  logic [1:0]      op_q;
  logic            neg_q, neg_r;

  logic            signed_q, ge, neg;
  logic [XLEN-1:0] shifted, sel;

  assign signed_q = ~op_q[0];
  assign shifted  = {r_q[XLEN-2:0], q_q[XLEN-1]};
  // r_msb is the bit shifted out of R: when set, the 33-bit partial remainder exceeds any divisor.
  assign ge       = r_msb | alu_cf;
  assign sel      = op_q[1] ? r_q : q_q;
  assign neg      = op_q[1] ? neg_r : neg_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy    = (state != S_IDLE);
    done    = 1'b0;
    alu_fn  = 4'b0000;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      S_IDLE: begin
        if (start && !kill) state_d = (divisor == '0) ? S_DONE : S_ABS_A;
      end
      S_ABS_A: begin
        alu_fn  = FN_SUB;
        alu_b   = a_abs;
        state_d = S_ABS_B;
      end
      S_ABS_B: begin
        alu_fn  = FN_SUB;
        alu_b   = b_abs;
        state_d = S_ITER;
      end
      S_ITER: begin
        alu_fn = FN_SUB;
        alu_a  = shifted;
        alu_b  = b_abs;
        if (cnt == 5'd31) state_d = S_SIGN;
      end
      S_SIGN: begin
        alu_fn  = FN_SUB;
        alu_b   = sel;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill && state != S_IDLE) state_d = S_IDLE;
  end

  // Datapath is frozen on kill so an aborted SIGN step cannot overwrite result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_abs  <= '0;
      b_abs  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      r_msb  <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (!kill) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            neg_q <= ~op[0] & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r <= ~op[0] & dividend[XLEN-1];
            a_abs <= dividend;
            b_abs <= divisor;
            if (divisor == '0) result <= op[1] ? dividend : '1;
          end
        end
        S_ABS_A: a_abs <= (signed_q && a_abs[XLEN-1]) ? alu_r : a_abs;
        S_ABS_B: begin
          b_abs <= (signed_q && b_abs[XLEN-1]) ? alu_r : b_abs;
          q_q   <= a_abs;
          r_q   <= '0;
          r_msb <= 1'b0;
          cnt   <= '0;
        end
        S_ITER: begin
          r_q   <= ge ? alu_r : shifted;
          r_msb <= ge ? alu_r[XLEN-1] : shifted[XLEN-1];
          q_q   <= {q_q[XLEN-2:0], ge};
          cnt   <= cnt + 5'd1;
        end
        S_SIGN: result <= neg ? alu_r : sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: behavioural ALU, RISC-V reference model, done-driven scoreboard.
module tb_alu_div_sequencer;

  logic        clk, rst, start, kill;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_r;
  logic [3:0]  alu_fn;
  logic        alu_cf;

  alu_div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend), .divisor(divisor),
    .kill(kill), .busy(busy), .done(done), .result(result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_fn(alu_fn), .alu_r(alu_r), .alu_cf(alu_cf)
  );

  // Shared ALU: only subtract and a default add are needed here.
  always_comb begin
    if (alu_fn == 4'b0001) begin
      alu_r  = alu_a - alu_b;
      alu_cf = (alu_a >= alu_b);
    end else begin
      alu_r  = alu_a + alu_b;
      alu_cf = 1'b0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sbq[$];
  string       tagq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0)                                              r = o[1] ? a : 32'hFFFF_FFFF;
    else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = o[1] ? 32'd0 : a;
    else begin
      case (o)
        2'b00:   r = $signed(a) / $signed(b);
        2'b01:   r = a / b;
        2'b10:   r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  exp_t  mon_e;
  string mon_tag;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
      else begin
        mon_e   = sbq.pop_front();
        mon_tag = tagq.pop_front();
        chk(mon_tag, result, mon_e.res);
        chk({mon_tag, "_lat"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        last_res = mon_e.res;
      end
    end
  end

  // Drives start for one cycle; returns at the negedge right after the accepting edge.
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    if (push) begin
      e.res = ref_div(o, a, b);
      e.lat = (b == 32'd0) ? 1 : 36;
      e.t0  = cyc;
      sbq.push_back(e);
      tagq.push_back(tag);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
      tagq.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b);
    issue(tag, o, a, b, 1'b1);
    drain(60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a",  alu_a, 32'd0);
    chk("rst_alu_b",  alu_b, 32'd0);
    chk("rst_alu_fn", {28'd0, alu_fn}, 32'd0);

    run("divu_100_7", 2'b01, 32'd100, 32'd7);
    run("remu_100_7", 2'b11, 32'd100, 32'd7);
    run("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2);
    run("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2);
    run("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE);
    run("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_by0",    2'b00, 32'h8000_0000, 32'd0);
    run("remu_by0",   2'b11, 32'd5, 32'd0);
    run("rem_m5_by0", 2'b10, 32'hFFFF_FFFB, 32'd0);
    run("divu_big",   2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 3) b = -b;
      run($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), a, b);
    end

    // start during ITER cycle 10 must not disturb the in-flight divide
    issue("divu_start_ign", 2'b01, 32'd1000, 32'd10, 1'b1);
    repeat (12) @(negedge clk);
    chk("iter_alu_fn", {28'd0, alu_fn}, 32'd1);
    start = 1'b1; op = 2'b00; dividend = 32'd5; divisor = 32'd0;
    @(negedge clk);
    start = 1'b0;
    drops = 0;
    for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
      if (!busy) drops++;
      @(negedge clk);
    end
    chk("busy_continuous", 32'(drops), 32'd0);
    drain(5);

    // reset in ITER cycle 20
    issue("", 2'b00, 32'hFFFF_FF9C, 32'd3, 1'b0);
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_alu_fn", {28'd0, alu_fn}, 32'd0);
    repeat (40) @(negedge clk);

    run("divu_77_7", 2'b01, 32'd77, 32'd7);

    // kill in ITER cycle 5
    issue("", 2'b01, 32'd500, 32'd4, 1'b0);
    repeat (7) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy",   {31'd0, busy}, 32'd0);
    chk("kill_result", result, last_res);
    repeat (40) @(negedge clk);
    chk("kill_result_held", result, last_res);

    run("divu_9_3", 2'b01, 32'd9, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
